// File: rtl/rf_writeback_arbiter.sv
// Register-file write-port arbiter: in-order WB has priority, and a 1-entry buffer holds
// one long-latency result until the port is free. Also tracks busy registers for ID hazards.
module rf_writeback_arbiter #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REGS       = 32,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wb_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [DATA_WIDTH-1:0]     wb_data_i,
    input  logic                      ll_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] ll_addr_i,
    input  logic [DATA_WIDTH-1:0]     ll_data_i,
    output logic                      ll_ready_o,
    input  logic                      issue_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr_i,
    input  logic                      id_rd_we_i,
    output logic                      hazard_stall_o,
    output logic                      wb_stall_o,
    output logic                      rf_we_o,
    output logic [REG_ADDR_WIDTH-1:0] rf_waddr_o,
    output logic [DATA_WIDTH-1:0]     rf_wdata_o
);

    localparam logic [3:0] STARVE_LIM4 = STARVE_LIMIT[3:0];

    logic [NUM_REGS-1:0]       busy_q, busy_d;
    logic                      buf_valid_q, buf_valid_d;
    logic [REG_ADDR_WIDTH-1:0] buf_addr_q, buf_addr_d;
    logic [DATA_WIDTH-1:0]     buf_data_q, buf_data_d;
    logic [3:0]                starve_q, starve_d;

    logic wb_write;
    logic drain;
    logic ll_accept;

    // A WB to register 0 is no write at all, so it never blocks the buffer.
    assign wb_write  = wb_valid_i && (wb_addr_i != '0);
    assign drain     = buf_valid_q && !wb_write;
    assign ll_accept = ll_valid_i && ll_ready_o;

    always_comb begin
        ll_ready_o = !rst && !buf_valid_q;
        wb_stall_o = !rst && buf_valid_q && (starve_q >= STARVE_LIM4);
    end

    always_comb begin
        rf_we_o    = 1'b0;
        rf_waddr_o = '0;
        rf_wdata_o = '0;
        if (!rst) begin
            if (wb_write) begin
                rf_we_o    = 1'b1;
                rf_waddr_o = wb_addr_i;
                rf_wdata_o = wb_data_i;
            end else if (buf_valid_q) begin
                rf_we_o    = 1'b1;
                rf_waddr_o = buf_addr_q;
                rf_wdata_o = buf_data_q;
            end
        end
    end

    // Index 0 is forced not-busy so x0 sources never stall.
    always_comb begin
        logic b_rs1, b_rs2, b_rd;
        b_rs1 = (id_rs1_addr_i != '0) && busy_q[id_rs1_addr_i];
        b_rs2 = (id_rs2_addr_i != '0) && busy_q[id_rs2_addr_i];
        b_rd  = (id_rd_addr_i  != '0) && busy_q[id_rd_addr_i];
        hazard_stall_o = !rst && (b_rs1 || b_rs2 || (id_rd_we_i && b_rd));
    end

    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        if (drain) begin
            buf_valid_d = 1'b0;
        end else if (ll_accept && (ll_addr_i != '0)) begin
            buf_valid_d = 1'b1;
            buf_addr_d  = ll_addr_i;
            buf_data_d  = ll_data_i;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (drain) begin
            starve_d = 4'd0;
        end else if (buf_valid_q && (starve_q != 4'hF)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // Clear before set so a same-cycle re-issue of the draining register stays busy.
    always_comb begin
        busy_d = busy_q;
        if (drain) begin
            busy_d[buf_addr_q] = 1'b0;
        end
        if (issue_valid_i && (issue_rd_i != '0)) begin
            busy_d[issue_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q      <= '0;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            starve_q    <= 4'd0;
        end else begin
            busy_q      <= busy_d;
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            starve_q    <= starve_d;
        end
    end

endmodule

// File: doc/rf_writeback_arbiter.md
Name: rf_writeback_arbiter

Overview:
- Shares the register file's single write port between two sources: the in-order pipeline writeback (WB) and a long-latency unit (LL, e.g. mul/div).
- Holds one LL result in a 1-entry buffer until the write port is free.
- Keeps a busy bitmap of registers whose LL results are still pending, and raises an ID-stage hazard stall against them.
- Sits between the WB stage, the LL unit and register_file; it drives that block's write port signals directly.

Parameters:
- REG_ADDR_WIDTH, 5, register address width.
- DATA_WIDTH, 32, register data width.
- NUM_REGS, 32, number of architectural registers (bitmap width).
- STARVE_LIMIT, 4, consecutive denied cycles before a bubble is requested from the pipeline (range 1..15).

Ports:
- clk  input  1  core clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- wb_valid_i  input  1  pipeline WB wants to write (RegWrite).
- wb_addr_i  input  REG_ADDR_WIDTH  WB destination register.
- wb_data_i  input  DATA_WIDTH  WB write data.
- ll_valid_i  input  1  LL result valid.
- ll_addr_i  input  REG_ADDR_WIDTH  LL destination register.
- ll_data_i  input  DATA_WIDTH  LL result data.
- ll_ready_o  output  1  LL result accepted this cycle when valid and ready are both 1.
- issue_valid_i  input  1  an LL op is issued this cycle.
- issue_rd_i  input  REG_ADDR_WIDTH  destination of the issued LL op.
- id_rs1_addr_i  input  REG_ADDR_WIDTH  ID source register 1.
- id_rs2_addr_i  input  REG_ADDR_WIDTH  ID source register 2.
- id_rd_addr_i  input  REG_ADDR_WIDTH  ID destination register.
- id_rd_we_i  input  1  ID instruction writes rd.
- hazard_stall_o  output  1  ID must stall: a source or destination register is busy.
- wb_stall_o  output  1  request a WB bubble next cycle (LL starving).
- rf_we_o  output  1  register file write enable.
- rf_waddr_o  output  REG_ADDR_WIDTH  register file write address.
- rf_wdata_o  output  DATA_WIDTH  register file write data.

Behaviour:
- Reset, asynchronous: busy bitmap = 0, buf_valid = 0, starvation counter = 0.
- While rst = 1: rf_we_o = 0, hazard_stall_o = 0, wb_stall_o = 0, ll_ready_o = 0. rf_waddr_o and rf_wdata_o = 0.
- LL buffer: ll_ready_o = !buf_valid (outside reset).
  - On ll_valid_i && ll_ready_o: capture addr/data and set buf_valid at the next edge.
  - An LL result with addr 0 is accepted and discarded; buf_valid stays 0.
- Write arbitration (combinational, same cycle):
  - wb_valid_i && wb_addr_i != 0: drive the WB write.
  - Else if buf_valid: drive the buffer write (the drain); buf_valid clears at the next edge.
  - Else rf_we_o = 0.
  - WB with addr 0 counts as no write, so the buffer may drain in that cycle.
- Drain and refill: the buffer cannot refill in the cycle it drains. ll_ready_o stays 0 in that cycle; effective throughput is one LL result per 2 cycles.
- Starvation counter (4 bits, saturating):
  - Increments each cycle buf_valid = 1 and the buffer is not granted.
  - Clears on drain.
  - wb_stall_o = (counter >= STARVE_LIMIT) && buf_valid.
  - If WB still asserts while wb_stall_o = 1, WB still wins; no data is lost.
- Busy bitmap:
  - On issue_valid_i with issue_rd_i != 0: set bit[issue_rd_i].
  - On drain: clear bit[buffer addr].
  - Same register set and cleared in one cycle: set wins. Bit 0 is never set.
- Hazard (combinational from the registered bitmap):
  - hazard_stall_o = busy[rs1] | busy[rs2] | (id_rd_we_i & busy[rd]); a 0 index reads as not busy.
  - A register draining this cycle still reads busy this cycle, because the register file updates at the edge. It is free the next cycle.
- Reset asserted mid-operation: any buffered LL result is lost; the LL unit is reset alongside this block.

Test Plan:
- Reset, then idle: rf_we_o = 0, ll_ready_o = 1, hazard_stall_o = 0, wb_stall_o = 0.
- WB only: wb_valid = 1, addr = 5, data = 0xDEADBEEF -> same cycle rf_we_o = 1, rf_waddr_o = 5, rf_wdata_o = 0xDEADBEEF.
- Issue and drain:
  - issue_rd = 7 at cycle 0 -> ID rs1 = 7 stalls from cycle 1.
  - LL result addr 7, data 0x12 accepted at cycle 3 -> buffer drains at cycle 4 with WB idle (rf_waddr_o = 7).
  - hazard_stall_o = 1 through cycle 4, 0 at cycle 5.
- Contention: buffer holds addr 9 while wb_valid = 1 continuously -> WB written each cycle; wb_stall_o = 1 after 4 denied cycles; the buffer drains in the first cycle wb_valid = 0; counter returns to 0.
- Addr-zero cases:
  - wb_addr = 0 with buffer full -> the buffer drains that cycle.
  - issue_rd = 0 -> no busy bit set.
  - LL addr 0 -> rf_we_o stays 0.
- Set/clear collision and reset:
  - Drain of reg 3 in the same cycle as a new issue to reg 3 -> bit 3 remains 1.
  - Assert rst with buf_valid = 1 -> buf_valid and all busy bits clear immediately, and rf_we_o = 0.
